// File: rtl/neuron_sched_pkg.sv
// Shared types and constants for the neuron scheduler: FSM states, config field codes and
// per-slot reset values.
package neuron_sched_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] F_W     = 2'd0;
    localparam logic [1:0] F_SHIFT = 2'd1;
    localparam logic [1:0] F_TETA  = 2'd2;
    localparam logic [1:0] F_CLR   = 2'd3;

    localparam int unsigned W_RST     = 1;
    localparam int unsigned SHIFT_RST = 1;
    localparam int unsigned TETA_RST  = 5;

endpackage

// File: rtl/neuron_slot_regs.sv
// Per-slot neuron configuration and state registers with config and sweep write ports.
// Optional per-slot saturating spike counters when SPIKE_COUNT_EN is defined.
module neuron_slot_regs
    import neuron_sched_pkg::*;
#(
    parameter int unsigned INPUTS      = 4,
    parameter int unsigned U_W         = 4,
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned IDX_W       = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_slot,
    input  logic [1:0]        cfg_field,
    input  logic [7:0]        cfg_data,
    input  logic              st_we,
    input  logic [IDX_W-1:0]  st_idx,
    input  logic [U_W-1:0]    st_u,
    input  logic              st_spike,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [INPUTS-1:0] rd_w,
    output logic [2:0]        rd_shift,
    output logic [U_W-1:0]    rd_teta,
    output logic [U_W-1:0]    rd_u,
    output logic              rd_was_spike
`ifdef SPIKE_COUNT_EN
    ,
    input  logic [IDX_W-1:0]  cnt_sel,
    output logic [7:0]        cnt_data
`endif
);

    logic [INPUTS-1:0] w_q     [NUM_NEURONS];
    logic [2:0]        shift_q [NUM_NEURONS];
    logic [U_W-1:0]    teta_q  [NUM_NEURONS];
    logic [U_W-1:0]    u_q     [NUM_NEURONS];
    logic              ws_q    [NUM_NEURONS];
`ifdef SPIKE_COUNT_EN
    logic [7:0]        cnt_q   [NUM_NEURONS];
`endif

    // Upper data bits beyond each field width are intentionally dropped.
    logic unused_cfg_data;
    assign unused_cfg_data = ^cfg_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                w_q[i]     <= INPUTS'(W_RST);
                shift_q[i] <= 3'(SHIFT_RST);
                teta_q[i]  <= U_W'(TETA_RST);
                u_q[i]     <= '0;
                ws_q[i]    <= 1'b0;
`ifdef SPIKE_COUNT_EN
                cnt_q[i]   <= 8'd0;
`endif
            end
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (cfg_we && cfg_slot == IDX_W'(i)) begin
                    unique case (cfg_field)
                        F_W:     w_q[i]     <= INPUTS'(cfg_data);
                        F_SHIFT: shift_q[i] <= cfg_data[2:0];
                        F_TETA:  teta_q[i]  <= U_W'(cfg_data);
                        F_CLR: begin
                            u_q[i]  <= '0;
                            ws_q[i] <= 1'b0;
`ifdef SPIKE_COUNT_EN
                            cnt_q[i] <= 8'd0;
`endif
                        end
                    endcase
                end
                if (st_we && st_idx == IDX_W'(i)) begin
                    u_q[i]  <= st_u;
                    ws_q[i] <= st_spike;
`ifdef SPIKE_COUNT_EN
                    if (st_spike && cnt_q[i] != 8'hFF) cnt_q[i] <= cnt_q[i] + 8'd1;
`endif
                end
            end
        end
    end

    assign rd_w         = w_q[rd_idx];
    assign rd_shift     = shift_q[rd_idx];
    assign rd_teta      = teta_q[rd_idx];
    assign rd_u         = u_q[rd_idx];
    assign rd_was_spike = ws_q[rd_idx];
`ifdef SPIKE_COUNT_EN
    assign cnt_data     = cnt_q[cnt_sel];
`endif

endmodule

// File: rtl/neuron_scheduler.sv
// Time-multiplexes one LIF neuron datapath across NUM_NEURONS virtual slots per timestep.
// Define SPIKE_COUNT_EN to add per-slot saturating spike counters (cnt_sel/cnt_data).
module neuron_scheduler
    import neuron_sched_pkg::*;
#(
    parameter int unsigned N_STAGES    = 2,
    parameter int unsigned INPUTS      = 2 ** N_STAGES,
    parameter int unsigned U_W         = N_STAGES + 2,
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [IDX_W+1:0]       cfg_addr,
    input  logic [7:0]             cfg_data,
    input  logic                   step_valid,
    output logic                   step_ready,
    input  logic [INPUTS-1:0]      step_x,
    output logic [INPUTS-1:0]      nrn_w,
    output logic [INPUTS-1:0]      nrn_x,
    output logic [2:0]             nrn_shift,
    output logic [U_W-1:0]         nrn_prev_u,
    output logic [U_W-1:0]         nrn_minus_teta,
    output logic                   nrn_was_spike,
    input  logic [U_W-1:0]         nrn_u_out,
    input  logic                   nrn_is_spike,
    output logic [NUM_NEURONS-1:0] spikes_out,
    output logic                   spikes_valid,
    output logic                   busy
`ifdef SPIKE_COUNT_EN
    ,
    input  logic [IDX_W-1:0]       cnt_sel,
    output logic [7:0]             cnt_data
`endif
);

    state_t                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [INPUTS-1:0]      x_q;
    logic [NUM_NEURONS-1:0] spk_acc_q;
    logic [NUM_NEURONS-1:0] spk_acc_d;
    logic                   last_slot;

    assign cfg_ready  = (state_q == IDLE);
    assign step_ready = (state_q == IDLE) && !cfg_valid;
    assign last_slot  = (idx_q == IDX_W'(NUM_NEURONS - 1));
    assign nrn_x      = x_q;

    // Merge the current slot's result so the final edge can publish the full vector.
    always_comb begin
        spk_acc_d        = spk_acc_q;
        spk_acc_d[idx_q] = nrn_is_spike;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            x_q          <= '0;
            spk_acc_q    <= '0;
            spikes_out   <= '0;
            spikes_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (step_valid && step_ready) begin
                        x_q     <= step_x;
                        idx_q   <= '0;
                        state_q <= RUN;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    spk_acc_q <= spk_acc_d;
                    idx_q     <= idx_q + IDX_W'(1);
                    if (last_slot) begin
                        state_q      <= DONE;
                        spikes_out   <= spk_acc_d;
                        spikes_valid <= 1'b1;
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    spikes_valid <= 1'b0;
                    busy         <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    neuron_slot_regs #(
        .INPUTS      (INPUTS),
        .U_W         (U_W),
        .NUM_NEURONS (NUM_NEURONS),
        .IDX_W       (IDX_W)
    ) u_slot_regs (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_we       (cfg_valid && cfg_ready),
        .cfg_slot     (cfg_addr[IDX_W+1:2]),
        .cfg_field    (cfg_addr[1:0]),
        .cfg_data     (cfg_data),
        .st_we        (state_q == RUN),
        .st_idx       (idx_q),
        .st_u         (nrn_u_out),
        .st_spike     (nrn_is_spike),
        .rd_idx       (idx_q),
        .rd_w         (nrn_w),
        .rd_shift     (nrn_shift),
        .rd_teta      (nrn_minus_teta),
        .rd_u         (nrn_prev_u),
        .rd_was_spike (nrn_was_spike)
`ifdef SPIKE_COUNT_EN
        ,
        .cnt_sel      (cnt_sel),
        .cnt_data     (cnt_data)
`endif
    );

endmodule

// File: tb/tb_neuron_scheduler.sv
// Self-checking bench for neuron_scheduler: neuron stub, transaction-level slot model,
// per-cycle output compare, plus fixed scenarios and randomized traffic.
module tb_neuron_scheduler;

    localparam int N_STAGES    = 2;
    localparam int INPUTS      = 4;
    localparam int U_W         = 4;
    localparam int NUM_NEURONS = 4;
    localparam int IDX_W       = 2;

    logic                   clk;
    logic                   rst_n;
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [IDX_W+1:0]       cfg_addr;
    logic [7:0]             cfg_data;
    logic                   step_valid;
    logic                   step_ready;
    logic [INPUTS-1:0]      step_x;
    logic [INPUTS-1:0]      nrn_w;
    logic [INPUTS-1:0]      nrn_x;
    logic [2:0]             nrn_shift;
    logic [U_W-1:0]         nrn_prev_u;
    logic [U_W-1:0]         nrn_minus_teta;
    logic                   nrn_was_spike;
    logic [U_W-1:0]         nrn_u_out;
    logic                   nrn_is_spike;
    logic [NUM_NEURONS-1:0] spikes_out;
    logic                   spikes_valid;
    logic                   busy;
`ifdef SPIKE_COUNT_EN
    logic [IDX_W-1:0]       cnt_sel;
    logic [7:0]             cnt_data;
`endif

    neuron_scheduler #(
        .N_STAGES    (N_STAGES),
        .INPUTS      (INPUTS),
        .U_W         (U_W),
        .NUM_NEURONS (NUM_NEURONS),
        .IDX_W       (IDX_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .step_valid     (step_valid),
        .step_ready     (step_ready),
        .step_x         (step_x),
        .nrn_w          (nrn_w),
        .nrn_x          (nrn_x),
        .nrn_shift      (nrn_shift),
        .nrn_prev_u     (nrn_prev_u),
        .nrn_minus_teta (nrn_minus_teta),
        .nrn_was_spike  (nrn_was_spike),
        .nrn_u_out      (nrn_u_out),
        .nrn_is_spike   (nrn_is_spike),
        .spikes_out     (spikes_out),
        .spikes_valid   (spikes_valid),
        .busy           (busy)
`ifdef SPIKE_COUNT_EN
        ,
        .cnt_sel        (cnt_sel),
        .cnt_data       (cnt_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Neuron stub: mode 0 spikes only on slot 2, mode 1 always spikes, mode 2 mixes inputs.
    int stub_mode = 0;
    int stub_slot = 0;

    function automatic logic [U_W-1:0] stub_u(input int mode, input logic [INPUTS-1:0] w,
                                              input logic [INPUTS-1:0] x,
                                              input logic [U_W-1:0] pu,
                                              input logic [U_W-1:0] teta, input logic ws);
        if (mode == 2) return pu + U_W'($countones(w & x)) + teta + U_W'(ws);
        return pu + U_W'(1);
    endfunction

    function automatic logic stub_spk(input int mode, input int slot,
                                      input logic [INPUTS-1:0] w, input logic [INPUTS-1:0] x,
                                      input logic [2:0] sh, input logic [U_W-1:0] pu,
                                      input logic ws);
        case (mode)
            0:       return slot == 2;
            1:       return 1'b1;
            default: return (^(w & x)) ^ ws ^ sh[0] ^ pu[1];
        endcase
    endfunction

    always_comb begin
        nrn_u_out    = stub_u(stub_mode, nrn_w, nrn_x, nrn_prev_u, nrn_minus_teta, nrn_was_spike);
        nrn_is_spike = stub_spk(stub_mode, stub_slot, nrn_w, nrn_x, nrn_shift, nrn_prev_u,
                                nrn_was_spike);
    end

    // Behavioural model of the slot file and published spike vector.
    logic [INPUTS-1:0]      m_w    [NUM_NEURONS];
    logic [2:0]             m_sh   [NUM_NEURONS];
    logic [U_W-1:0]         m_teta [NUM_NEURONS];
    logic [U_W-1:0]         m_u    [NUM_NEURONS];
    logic                   m_ws   [NUM_NEURONS];
    int                     m_cnt  [NUM_NEURONS];
    logic [INPUTS-1:0]      m_x;
    logic [NUM_NEURONS-1:0] m_spikes;

    logic [U_W-1:0]    obs_u    [NUM_NEURONS];
    logic [U_W-1:0]    obs_teta [NUM_NEURONS];
    logic [INPUTS-1:0] obs_w    [NUM_NEURONS];

    task automatic model_reset();
        for (int i = 0; i < NUM_NEURONS; i++) begin
            m_w[i] = 1; m_sh[i] = 1; m_teta[i] = 5; m_u[i] = 0; m_ws[i] = 0; m_cnt[i] = 0;
        end
        m_x = '0;
        m_spikes = '0;
    endtask

    task automatic apply_cfg(input logic [IDX_W+1:0] addr, input logic [7:0] data);
        int s;
        s = int'(addr[IDX_W+1:2]);
        case (addr[1:0])
            2'd0: m_w[s]    = data[INPUTS-1:0];
            2'd1: m_sh[s]   = data[2:0];
            2'd2: m_teta[s] = data[U_W-1:0];
            default: begin m_u[s] = 0; m_ws[s] = 0; m_cnt[s] = 0; end
        endcase
    endtask

    // Expected outputs for the current cycle, consumed by the compare process.
    logic                   chk_en = 1'b0;
    logic [INPUTS-1:0]      exp_w, exp_x;
    logic [2:0]             exp_sh;
    logic [U_W-1:0]         exp_u, exp_teta;
    logic                   exp_ws, exp_sv, exp_busy, exp_cready, exp_sready;
    logic [NUM_NEURONS-1:0] exp_spikes;

    task automatic set_exp(input int slot, input bit bsy, input bit done);
        exp_w      = m_w[slot];
        exp_x      = m_x;
        exp_sh     = m_sh[slot];
        exp_u      = m_u[slot];
        exp_teta   = m_teta[slot];
        exp_ws     = m_ws[slot];
        exp_spikes = m_spikes;
        exp_sv     = done;
        exp_busy   = bsy;
        exp_cready = !bsy;
        exp_sready = !bsy && !cfg_valid;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("nrn_w", nrn_w, exp_w);
            chk("nrn_x", nrn_x, exp_x);
            chk("nrn_shift", nrn_shift, exp_sh);
            chk("nrn_prev_u", nrn_prev_u, exp_u);
            chk("nrn_minus_teta", nrn_minus_teta, exp_teta);
            chk("nrn_was_spike", nrn_was_spike, exp_ws);
            chk("spikes_out", spikes_out, exp_spikes);
            chk("spikes_valid", spikes_valid, exp_sv);
            chk("busy", busy, exp_busy);
            chk("cfg_ready", cfg_ready, exp_cready);
            chk("step_ready", step_ready, exp_sready);
`ifdef SPIKE_COUNT_EN
            chk("cnt_data", cnt_data, m_cnt[cnt_sel]);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
`ifdef SPIKE_COUNT_EN
        cnt_sel = IDX_W'($urandom_range(0, NUM_NEURONS - 1));
`endif
    endtask

    task automatic do_cfg(input int slot, input int field, input int data);
        cfg_valid = 1'b1;
        cfg_addr  = {IDX_W'(slot), 2'(field)};
        cfg_data  = 8'(data);
        set_exp(0, 0, 0);
        cyc();
        apply_cfg(cfg_addr, cfg_data);
        cfg_valid = 1'b0;
        set_exp(0, 0, 0);
    endtask

    // Full timestep; with hold_cfg a pre-loaded config request is held across the sweep.
    task automatic do_step(input logic [INPUTS-1:0] x, input bit hold_cfg);
        logic [U_W-1:0]         nu;
        logic                   ns;
        logic [NUM_NEURONS-1:0] acc;
        acc        = '0;
        step_valid = 1'b1;
        step_x     = x;
        set_exp(0, 0, 0);
        cyc();
        step_valid = 1'b0;
        m_x        = x;
        if (hold_cfg) cfg_valid = 1'b1;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            stub_slot   = i;
            set_exp(i, 1, 0);
            obs_u[i]    = nrn_prev_u;
            obs_teta[i] = nrn_minus_teta;
            obs_w[i]    = nrn_w;
            nu = stub_u(stub_mode, m_w[i], m_x, m_u[i], m_teta[i], m_ws[i]);
            ns = stub_spk(stub_mode, i, m_w[i], m_x, m_sh[i], m_u[i], m_ws[i]);
            cyc();
            m_u[i]  = nu;
            m_ws[i] = ns;
            acc[i]  = ns;
            if (ns && m_cnt[i] < 255) m_cnt[i]++;
        end
        m_spikes  = acc;
        stub_slot = 0;
        set_exp(0, 1, 1);
        cyc();
        if (hold_cfg) begin
            set_exp(0, 0, 0);
            cyc();
            apply_cfg(cfg_addr, cfg_data);
            cfg_valid = 1'b0;
        end
        set_exp(0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
        step_valid = 1'b0; step_x = '0;
`ifdef SPIKE_COUNT_EN
        cnt_sel = '0;
`endif
        model_reset();
        cyc();
        set_exp(0, 0, 0);
        chk_en = 1'b1;
        chk("rst_spikes_out", spikes_out, 0);
        chk("rst_step_ready", step_ready, 1);
        chk("rst_w", nrn_w, 1);
        chk("rst_shift", nrn_shift, 1);
        chk("rst_minus_teta", nrn_minus_teta, 5);
        chk("rst_prev_u", nrn_prev_u, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Stub spikes only on slot 2; all slots start at reset values.
        stub_mode = 0;
        do_step(4'b1011, 1'b0);
        for (int i = 0; i < NUM_NEURONS; i++) begin
            chk("step1_prev_u", obs_u[i], 0);
            chk("step1_w", obs_w[i], 1);
            chk("step1_teta", obs_teta[i], 5);
        end
        chk("step1_spikes_out", spikes_out, 4'b0100);
        do_step(4'b0110, 1'b0);
        for (int i = 0; i < NUM_NEURONS; i++) chk("step2_prev_u", obs_u[i], 1);

        // Config and step together: config wins, step follows a cycle later.
        cfg_valid  = 1'b1; cfg_addr = {2'd1, 2'd2}; cfg_data = 8'h07;
        step_valid = 1'b1; step_x = 4'b0011;
        set_exp(0, 0, 0);
        cyc();
        apply_cfg(cfg_addr, cfg_data);
        cfg_valid = 1'b0;
        do_step(4'b0011, 1'b0);
        chk("prio_teta_slot1", obs_teta[1], 7);

        // Config held during a sweep lands only once back in IDLE.
        cfg_addr = {2'd2, 2'd0}; cfg_data = 8'hA5;
        do_step(4'b1111, 1'b1);
        chk("run_cfg_w_before", obs_w[2], 1);
        do_step(4'b1000, 1'b0);
        chk("run_cfg_w_after", obs_w[2], 4'h5);

        // Reset mid-sweep at idx 2.
        step_valid = 1'b1; step_x = 4'b0101;
        set_exp(0, 0, 0);
        cyc();
        step_valid = 1'b0;
        m_x = 4'b0101;
        for (int i = 0; i < 2; i++) begin
            stub_slot = i;
            set_exp(i, 1, 0);
            m_u[i]  = stub_u(stub_mode, m_w[i], m_x, m_u[i], m_teta[i], m_ws[i]);
            m_ws[i] = stub_spk(stub_mode, i, m_w[i], m_x, m_sh[i], m_u[i], m_ws[i]);
            cyc();
        end
        rst_n = 1'b0;
        model_reset();
        stub_slot = 0;
        #1;
        set_exp(0, 0, 0);
        chk("abort_busy", busy, 0);
        chk("abort_valid", spikes_valid, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < NUM_NEURONS + 3; i++) cyc();
        do_step(4'b1001, 1'b0);
        for (int i = 0; i < NUM_NEURONS; i++) begin
            chk("abort_prev_u", obs_u[i], 0);
            chk("abort_teta", obs_teta[i], 5);
            chk("abort_w", obs_w[i], 1);
        end

        // Randomized config/step traffic against the model.
        stub_mode = 2;
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0: do_cfg(int'($urandom_range(0, NUM_NEURONS - 1)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 255)));
                1: do_step(INPUTS'($urandom), 1'b0);
                2: begin
                    cfg_valid  = 1'b1;
                    cfg_addr   = (IDX_W + 2)'($urandom);
                    cfg_data   = 8'($urandom);
                    step_valid = 1'b1;
                    step_x     = INPUTS'($urandom);
                    set_exp(0, 0, 0);
                    cyc();
                    apply_cfg(cfg_addr, cfg_data);
                    cfg_valid = 1'b0;
                    do_step(step_x, 1'b0);
                end
                default: begin
                    cfg_addr = (IDX_W + 2)'($urandom);
                    cfg_data = 8'($urandom);
                    do_step(INPUTS'($urandom), 1'b1);
                end
            endcase
        end

`ifdef SPIKE_COUNT_EN
        stub_mode = 1;
        for (int n = 0; n < 300; n++) do_step(INPUTS'($urandom), 1'b0);
        for (int i = 0; i < NUM_NEURONS; i++) begin
            cnt_sel = IDX_W'(i);
            #1;
            chk("cnt_sat", cnt_data, 255);
        end
        do_cfg(0, 3, 0);
        cnt_sel = '0;
        #1;
        chk("cnt_clr_slot0", cnt_data, 0);
        cnt_sel = IDX_W'(1);
        #1;
        chk("cnt_keep_slot1", cnt_data, 255);
`endif

        cyc();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
